// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared receiver FSM states and prescale helpers
package aes_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam logic [15:0] MIN_PRESCALE = 16'd4;

  // Very small bit periods cannot centre the sample point, so they are raised to the minimum.
  function automatic logic [15:0] clamp_prescale(input logic [15:0] ps);
    return (ps < MIN_PRESCALE) ? MIN_PRESCALE : ps;
  endfunction

endpackage

// File: rtl/my_axis_if.sv
// rtl/my_axis_if.sv - byte stream interface carrying received characters
interface my_axis_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [DATA_W/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-stage synchroniser for the asynchronous serial line
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Reset to 1 so an idle-high line never looks like a start bit coming out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_idle.sv
// rtl/uart_rx_idle.sv - UART receiver with byte stream output and line-idle detection
module uart_rx_idle
  import aes_uart_pkg::*;
#(
  parameter int IDLE_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] prescale,
  input  logic        parity_en,
  input  logic        parity_odd,
  my_axis_if.master   m_axis,
  output logic        idle,
  output logic        busy,
  output logic        frame_error,
  output logic        parity_error,
  output logic        overrun_error
);

  rx_state_e   r_state;
  rx_state_e   w_next_state;
  logic        w_rxd;
  logic [15:0] w_ps;
  logic        w_tick;
  logic        w_start_det;
  logic        w_shift;
  logic        w_par_chk;
  logic        w_stop_high;
  logic        w_stop_low;
  logic        w_good_byte;
  logic [31:0] w_idle_limit;

  logic [15:0] r_prescale;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_frame_bad;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_frame_error;
  logic        r_parity_error;
  logic        r_overrun_error;
  logic [31:0] r_idle_cnt;
  logic        r_armed;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (rxd),
    .o_q   (w_rxd)
  );

  assign w_ps         = clamp_prescale(prescale);
  assign w_tick       = (r_timer == 16'd1);
  assign w_good_byte  = w_stop_high && !r_frame_bad;
  assign w_idle_limit = 32'(IDLE_BITS) * {16'd0, r_prescale};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_det  = 1'b0;
    w_shift      = 1'b0;
    w_par_chk    = 1'b0;
    w_stop_high  = 1'b0;
    w_stop_low   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!w_rxd) begin
          w_start_det  = 1'b1;
          w_next_state = RX_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          w_next_state = w_rxd ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_next_state = parity_en ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (w_tick) begin
          w_par_chk    = 1'b1;
          w_next_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (w_rxd) begin
            w_stop_high  = 1'b1;
            w_next_state = RX_IDLE;
          end else begin
            w_stop_low   = 1'b1;
            w_next_state = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rxd) begin
          w_next_state = RX_IDLE;
        end
      end
      default: w_next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale      <= '0;
      r_timer         <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_frame_bad     <= 1'b0;
      r_tdata         <= '0;
      r_tvalid        <= 1'b0;
      r_frame_error   <= 1'b0;
      r_parity_error  <= 1'b0;
      r_overrun_error <= 1'b0;
      r_idle_cnt      <= '0;
      r_armed         <= 1'b0;
    end else begin
      r_frame_error   <= 1'b0;
      r_parity_error  <= 1'b0;
      r_overrun_error <= 1'b0;

      // The half-period first load puts every later sample in the middle of its bit.
      if (w_start_det) begin
        r_prescale  <= w_ps;
        r_timer     <= w_ps >> 1;
        r_bit_cnt   <= '0;
        r_frame_bad <= 1'b0;
        r_armed     <= 1'b0;
      end else if (r_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
        r_timer <= w_tick ? r_prescale : r_timer - 16'd1;
      end

      if (w_shift) begin
        r_shift   <= {w_rxd, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_par_chk && ((^r_shift ^ w_rxd) != parity_odd)) begin
        r_frame_bad    <= 1'b1;
        r_parity_error <= 1'b1;
      end

      if (w_stop_low) begin
        r_frame_error <= 1'b1;
      end

      // A held byte wins over a new one; acceptance in the same cycle frees the slot.
      if (w_good_byte) begin
        if (r_tvalid && !m_axis.tready) begin
          r_overrun_error <= 1'b1;
        end else begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end
      end else if (r_tvalid && m_axis.tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_stop_high) begin
        r_idle_cnt <= '0;
      end else if ((r_state == RX_IDLE) && w_rxd && (r_idle_cnt < w_idle_limit)) begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
      end

      if (w_good_byte) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = 1'b0;
  assign m_axis.tkeep  = '1;

  assign idle = r_armed && (r_idle_cnt >= w_idle_limit) && !r_tvalid
                && (r_state == RX_IDLE) && w_rxd;
  assign busy          = (r_state != RX_IDLE);
  assign frame_error   = r_frame_error;
  assign parity_error  = r_parity_error;
  assign overrun_error = r_overrun_error;

endmodule

// File: tb/tb_uart_rx_idle.sv
// tb/tb_uart_rx_idle.sv - directed scoreboard bench for uart_rx_idle
module tb_uart_rx_idle;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [15:0] prescale;
  logic        parity_en;
  logic        parity_odd;
  logic        idle;
  logic        busy;
  logic        frame_error;
  logic        parity_error;
  logic        overrun_error;

  my_axis_if #(.DATA_W(8)) axis ();

  uart_rx_idle #(
    .IDLE_BITS   (10),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .m_axis        (axis),
    .idle          (idle),
    .busy          (busy),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         fe_cnt = 0, pe_cnt = 0, oe_cnt = 0;
  int         rise_cnt = 0, rise_cyc = 0;
  int         idle_rise_cnt = 0, idle_rise_cyc = 0, idle_fall_cyc = 0;
  logic       tv_q = 1'b0, idle_q = 1'b0;
  logic [7:0] got_data [0:63];
  int         got_cnt = 0;

  always @(negedge clk) begin
    tv_q   <= axis.tvalid;
    idle_q <= idle;
    if (axis.tvalid && !tv_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (axis.tvalid && axis.tready) begin
      got_data[got_cnt[5:0]] <= axis.tdata;
      got_cnt <= got_cnt + 1;
    end
    if (frame_error)   fe_cnt <= fe_cnt + 1;
    if (parity_error)  pe_cnt <= pe_cnt + 1;
    if (overrun_error) oe_cnt <= oe_cnt + 1;
    if (idle && !idle_q) begin
      idle_rise_cnt <= idle_rise_cnt + 1;
      idle_rise_cyc <= cyc;
    end
    if (!idle && idle_q) idle_fall_cyc <= cyc;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  int         rd_idx = 0;
  int         t0 = 0;
  int         fe0, pe0, oe0, rc0, ir0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b, input int p, input bit with_par, input bit par_bit);
    t0  = cyc;
    rxd = 1'b0;
    wait_clk(p);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(p);
    end
    if (with_par) begin
      rxd = par_bit;
      wait_clk(p);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int p, input bit with_par, input bit par_bit);
    send_head(b, p, with_par, par_bit);
    rxd = 1'b1;
    wait_clk(p);
  endtask

  task automatic expect_byte(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (got_cnt <= rd_idx && n < 2000) begin
      wait_clk(1);
      n++;
    end
    check({tag, "_arrived"}, 32'(got_cnt > rd_idx), 32'd1);
    if (got_cnt > rd_idx && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(got_data[rd_idx[5:0]]), 32'(e));
      rd_idx++;
    end
  endtask

  task automatic snap();
    fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt; rc0 = rise_cnt; ir0 = idle_rise_cnt;
  endtask

  initial begin
    int d;
    rst         = 1'b1;
    rxd         = 1'b1;
    prescale    = 16'd16;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;
    axis.tready = 1'b1;
    wait_clk(3);

    check("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst_tdata", 32'(axis.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    check("rst_errs", 32'({frame_error, parity_error, overrun_error}), 32'd0);
    rst = 1'b0;
    wait_clk(200);
    check("idle_before_first_frame", 32'(idle), 32'd0);

    // 8N1 0xA5 with latency window around the stop-bit centre
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 16, 1'b0, 1'b0);
    expect_byte("a5_data");
    d = rise_cyc - t0;
    check("a5_latency_window", 32'(d >= 152 && d <= 158), 32'd1);
    check("a5_no_errors", 32'(fe_cnt + pe_cnt + oe_cnt - fe0 - pe0 - oe0), 32'd0);

    // idle rises IDLE_BITS*prescale clocks after the stop sample, drops on start edge
    wait_clk(10);
    snap();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b0, 1'b0);
    expect_byte("3c_data");
    wait_clk(200);
    check("idle_rose_once", 32'(idle_rise_cnt - ir0), 32'd1);
    check("idle_rise_delay", 32'(idle_rise_cyc - rise_cyc), 32'd160);
    check("idle_level", 32'(idle), 32'd1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 16, 1'b0, 1'b0);
    check("idle_fall_on_start", 32'(idle_fall_cyc - t0), 32'(SYNC));
    expect_byte("5a_data");

    // short glitch on the line
    wait_clk(20);
    snap();
    rxd = 1'b0;
    wait_clk(4);
    check("glitch_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    wait_clk(40);
    check("glitch_back_idle", 32'(busy), 32'd0);
    check("glitch_no_output", 32'(rise_cnt - rc0), 32'd0);
    check("glitch_no_errors", 32'(fe_cnt + pe_cnt + oe_cnt - fe0 - pe0 - oe0), 32'd0);
    check("glitch_disarms_idle", 32'(idle), 32'd0);

    // prescale below minimum behaves as 4
    prescale = 16'd2;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 4, 1'b0, 1'b0);
    expect_byte("clamp_c3_data");
    prescale = 16'd8;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 8, 1'b0, 1'b0);
    expect_byte("ps8_81_data");
    prescale = 16'd16;

    // parity
    wait_clk(10);
    snap();
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    send_frame(8'h03, 16, 1'b1, 1'b0);
    wait_clk(20);
    check("par_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_no_output", 32'(rise_cnt - rc0), 32'd0);
    check("par_bad_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 16, 1'b1, 1'b0);
    expect_byte("par_odd_07_data");
    parity_odd = 1'b0;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 16, 1'b1, 1'b0);
    expect_byte("par_even_f0_data");
    check("par_good_no_pulse", 32'(pe_cnt - pe0), 32'd1);

    // stop bit held low for three bit periods
    parity_en = 1'b0;
    wait_clk(10);
    snap();
    send_head(8'h55, 16, 1'b0, 1'b0);
    rxd = 1'b0;
    wait_clk(48);
    check("break_busy", 32'(busy), 32'd1);
    check("break_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("break_no_output", 32'(rise_cnt - rc0), 32'd0);
    rxd = 1'b1;
    wait_clk(16);
    check("break_released", 32'(busy), 32'd0);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 16, 1'b0, 1'b0);
    expect_byte("after_break_66_data");

    // parity mismatch and bad stop in the same frame
    wait_clk(10);
    snap();
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_head(8'h01, 16, 1'b1, 1'b0);
    rxd = 1'b0;
    wait_clk(16);
    rxd = 1'b1;
    wait_clk(20);
    check("both_parity_err", 32'(pe_cnt - pe0), 32'd1);
    check("both_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("both_no_output", 32'(rise_cnt - rc0), 32'd0);
    parity_en = 1'b0;

    // overrun while the consumer stalls
    wait_clk(10);
    snap();
    axis.tready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 16, 1'b0, 1'b0);
    send_frame(8'h22, 16, 1'b0, 1'b0);
    wait_clk(5);
    check("overrun_pulse_once", 32'(oe_cnt - oe0), 32'd1);
    check("overrun_tvalid_held", 32'(axis.tvalid), 32'd1);
    check("overrun_tdata_kept", 32'(axis.tdata), 32'h11);
    check("overrun_nothing_taken", 32'(got_cnt - rd_idx), 32'd0);
    axis.tready = 1'b1;
    expect_byte("overrun_11_data");
    wait_clk(5);
    check("overrun_22_dropped", 32'(got_cnt - rd_idx), 32'd0);
    check("overrun_tvalid_clear", 32'(axis.tvalid), 32'd0);

    // reset in the middle of a frame
    wait_clk(10);
    snap();
    rxd = 1'b0;
    wait_clk(16);
    rxd = 1'b1;
    wait_clk(40);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tvalid", 32'(axis.tvalid), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    check("midrst_idle_state", 32'(busy), 32'd0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 16, 1'b0, 1'b0);
    expect_byte("after_rst_96_data");
    wait_clk(10);
    check("midrst_one_output", 32'(rise_cnt - rc0), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_idle.md
UART_RX_IDLE -- requirements
Module: uart_rx_idle

Interface
REQ-001 Parameter: IDLE_BITS, 10, number of idle bit periods after the last stop bit before `idle` asserts.
REQ-002 Parameter: SYNC_STAGES, 2, number of flip-flops in the rxd synchroniser (minimum 2).
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: rxd  input  1  serial line, idle-high, LSB first.
REQ-006 Port: prescale  input  16  clk cycles per bit; captured at start-edge detection.
REQ-007 Port: parity_en  input  1  expect one parity bit after the data bits.
REQ-008 Port: parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 Port: m_axis  my_axis_if.master  8  received byte; tlast fixed 0, tkeep fixed all-ones.
REQ-010 Port: idle  output  1  line-idle level consumed by regs_aes_bridge for partial-block flush.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-013 Port: parity_error  output  1  one-cycle pulse on a parity mismatch.
REQ-014 Port: overrun_error  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-015 rxd SHALL pass through SYNC_STAGES flip-flops (reset value 1) before any use; sampling SHALL use only the synchronised value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-017 IDLE: synchronised rxd low SHALL latch prescale (values below 4 treated as 4), load the timer with prescale/2, and enter START.
REQ-018 START: at timer expiry, rxd low SHALL enter DATA with the timer reloaded to prescale; rxd high SHALL return to IDLE as a glitch, with no error and no output.
REQ-019 DATA: at each expiry the FSM SHALL shift in rxd LSB first; after 8 bits it SHALL enter PARITY if parity_en, otherwise STOP.
REQ-020 PARITY: the FSM SHALL compare the XOR of the 8 data bits and the parity bit against parity_odd; on mismatch it SHALL flag the frame bad and pulse parity_error.
REQ-021 STOP, rxd high at sample: if the frame is good, the byte SHALL be presented; the FSM SHALL return to IDLE.
REQ-022 STOP, rxd low at sample: frame_error SHALL pulse, the byte SHALL be discarded, and the FSM SHALL enter WAIT_HIGH.
REQ-023 WAIT_HIGH (break handling): the FSM SHALL leave for IDLE only after rxd is high; the idle counter SHALL NOT run.
REQ-024 Output register: m_axis.tvalid SHALL assert the cycle after the stop-bit sample and hold, with tdata stable, until tvalid && tready.
REQ-025 Overrun: if a new good byte completes while tvalid && !tready, the new byte SHALL be dropped, the old byte kept, and overrun_error pulsed; simultaneous completion and acceptance is not an overrun, and the new byte SHALL load.
REQ-026 Idle counter: it SHALL clear on each good stop bit, count clk cycles while in IDLE with rxd high, and saturate at IDLE_BITS*prescale.
REQ-027 idle SHALL be high only when all three hold: the counter is saturated, m_axis.tvalid is 0, and the FSM is in IDLE.
REQ-028 idle SHALL drop on the cycle a start edge is detected.
REQ-029 idle SHALL be re-armed only by a subsequent good frame, and SHALL remain 0 after reset until the first good frame.
REQ-030 Error pulses are independent; parity_error and frame_error SHALL both pulse for the same frame when both conditions occur.

Reset
REQ-031 Asynchronous assertion SHALL force: FSM IDLE; tvalid 0; tdata 0x00; busy, idle and all error outputs 0; synchroniser stages 1; counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no output; the next frame SHALL be received normally.

Structure
REQ-033 aes_uart_pkg SHALL hold the rx FSM state enum and the minimum-prescale constant (4).
REQ-034 One sub-module, uart_rx_sync (parameterised SYNC_STAGES synchroniser), SHALL be instantiated.

Verification
REQ-035 prescale=16, 8N1 frame 0xA5 -> tdata=0xA5, tvalid 1 cycle after the stop sample; no error pulses.
REQ-036 rxd low for 4 clocks only (prescale=16) -> no tvalid, no error, FSM back in IDLE, busy low.
REQ-037 parity_en=1, parity_odd=1, byte 0x03 sent with parity bit 0 -> parity_error pulse, no tvalid.
REQ-038 Stop bit held low for 3 bit periods -> frame_error pulse, no tvalid, no new frame accepted until rxd high.
REQ-039 tready=0, bytes 0x11 then 0x22 -> overrun_error pulse once; tdata stays 0x11 until accepted.
REQ-040 prescale=16, IDLE_BITS=10, byte 0x3C accepted immediately -> idle rises 160 clocks after the stop sample; falls on the next start edge.
